trap_unit: RTL and testbench

Parametrised machine-mode trap controller for the 5-stage RISC-V core, with its own CSR file. It owns mstatus, mie, mip, mtvec, mepc, mcause, mtval and mscratch. It takes synchronous exceptions and NUM_IRQ external interrupt lines, sequences trap entry and mret through an FSM, and drives pipeline flush, stall and PC redirect. It sits alongside the MEM/WB boundary; CSR instructions are serviced from MEM.

---
 rtl/trap_pkg.sv | 37 +++
 rtl/trap_unit_if.sv | 37 +++
 rtl/trap_csr_file.sv | 149 ++++++++++++++
 rtl/trap_unit.sv | 146 ++++++++++++++
 tb/tb_trap_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared constants and types for the machine-mode trap controller
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam logic [1:0] CSR_OP_READ  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
    localparam logic [3:0] EXC_LOAD_FAULT  = 4'd5;
    localparam logic [3:0] EXC_STORE_FAULT = 4'd7;
    localparam logic [3:0] EXC_ECALL_M     = 4'd11;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

    // External interrupt lines occupy mip/mie from this bit upward.
    localparam int IRQ_BASE = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAP,
        ST_MRET
    } trap_state_e;

endpackage

// File: rtl/trap_unit_if.sv
// rtl/trap_unit_if.sv - pipeline-to-trap-controller bus
// slave modport: trap_unit side (CSR request, exception/mret/irq in; rdata, flush, stall, redirect out)
// master modport: pipeline side
interface trap_unit_if #(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 4
);
    logic               csr_valid;
    logic [1:0]         csr_op;
    logic [11:0]        csr_addr;
    logic [XLEN-1:0]    csr_wdata;
    logic [XLEN-1:0]    csr_rdata;
    logic               csr_illegal;
    logic [NUM_IRQ-1:0] irq;
    logic               exc_valid;
    logic [3:0]         exc_code;
    logic [XLEN-1:0]    exc_pc;
    logic [XLEN-1:0]    exc_tval;
    logic               mret;
    logic [XLEN-1:0]    pc_next;
    logic               flush;
    logic               stall;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;

    modport slave (
        input  csr_valid, csr_op, csr_addr, csr_wdata, irq,
        input  exc_valid, exc_code, exc_pc, exc_tval, mret, pc_next,
        output csr_rdata, csr_illegal, flush, stall, redirect_valid, redirect_pc
    );

    modport master (
        output csr_valid, csr_op, csr_addr, csr_wdata, irq,
        output exc_valid, exc_code, exc_pc, exc_tval, mret, pc_next,
        input  csr_rdata, csr_illegal, flush, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_csr_file.sv
// rtl/trap_csr_file.sv - machine-mode CSR storage, read mux, write masks and set/clear
// csr_we_i/op/addr/wdata: gated CSR write request; csr_rdata_o/csr_legal_o: raw read value and decode
// trap_commit_i/mret_commit_i: trap entry and mret updates; mstatus_mie_o/mie_o/mip_o/mtvec_o/mepc_o: state to FSM
module trap_csr_file
    import trap_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              NUM_IRQ     = 4,
    parameter bit              VECTORED_EN = 1'b1,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               csr_we_i,
    input  logic [1:0]         csr_op_i,
    input  logic [11:0]        csr_addr_i,
    input  logic [XLEN-1:0]    csr_wdata_i,
    output logic [XLEN-1:0]    csr_rdata_o,
    output logic               csr_legal_o,
    input  logic               trap_commit_i,
    input  logic [XLEN-1:0]    trap_epc_i,
    input  logic [XLEN-1:0]    trap_cause_i,
    input  logic [XLEN-1:0]    trap_tval_i,
    input  logic               mret_commit_i,
    output logic               mstatus_mie_o,
    output logic [NUM_IRQ-1:0] mie_o,
    output logic [NUM_IRQ-1:0] mip_o,
    output logic [XLEN-1:0]    mtvec_o,
    output logic [XLEN-1:0]    mepc_o
);
    // Only mode 0/1 survive; mode is hardwired 0 without vectored support.
    localparam logic [XLEN-1:0] MTVEC_RST =
        {RESET_MTVEC[XLEN-1:2], 1'b0, VECTORED_EN && (RESET_MTVEC[1:0] == 2'b01)};

    logic               mie_bit_q, mie_bit_d, mpie_q, mpie_d;
    logic [NUM_IRQ-1:0] mie_q, mie_d, mip_q, mip_d;
    logic [XLEN-1:0]    mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [XLEN-1:0]    mcause_q, mcause_d, mtval_q, mtval_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0]    mstatus_val, mie_val, mip_val, wval;
    logic               do_write;

    always_comb begin
        mstatus_val = '0;
        mstatus_val[MSTATUS_MIE_BIT]  = mie_bit_q;
        mstatus_val[MSTATUS_MPIE_BIT] = mpie_q;
        mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mie_val = '0;
        mie_val[IRQ_BASE +: NUM_IRQ] = mie_q;
        mip_val = '0;
        mip_val[IRQ_BASE +: NUM_IRQ] = mip_q;
    end

    always_comb begin
        csr_rdata_o = '0;
        csr_legal_o = 1'b1;
        case (csr_addr_i)
            CSR_MSTATUS:  csr_rdata_o = mstatus_val;
            CSR_MIE:      csr_rdata_o = mie_val;
            CSR_MTVEC:    csr_rdata_o = mtvec_q;
            CSR_MSCRATCH: csr_rdata_o = mscratch_q;
            CSR_MEPC:     csr_rdata_o = mepc_q;
            CSR_MCAUSE:   csr_rdata_o = mcause_q;
            CSR_MTVAL:    csr_rdata_o = mtval_q;
            CSR_MIP:      csr_rdata_o = mip_val;
            default:      csr_legal_o = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op_i)
            CSR_OP_WRITE: wval = csr_wdata_i;
            CSR_OP_SET:   wval = csr_rdata_o | csr_wdata_i;
            CSR_OP_CLEAR: wval = csr_rdata_o & ~csr_wdata_i;
            default:      wval = csr_rdata_o;
        endcase
        // Set/clear with a zero operand must not write (csrrs/csrrc x0 are pure reads).
        do_write = csr_we_i && csr_legal_o &&
                   ((csr_op_i == CSR_OP_WRITE) ||
                    ((csr_op_i != CSR_OP_READ) && (csr_wdata_i != '0)));
    end

    always_comb begin
        mie_bit_d  = mie_bit_q;
        mpie_d     = mpie_q;
        mie_d      = mie_q;
        mip_d      = irq_i;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mscratch_d = mscratch_q;
        if (trap_commit_i) begin
            mpie_d    = mie_bit_q;
            mie_bit_d = 1'b0;
            mepc_d    = trap_epc_i & ~XLEN'(3);
            mcause_d  = trap_cause_i;
            mtval_d   = trap_tval_i;
        end else if (mret_commit_i) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
        end else if (do_write) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mie_bit_d = wval[MSTATUS_MIE_BIT];
                    mpie_d    = wval[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_d      = wval[IRQ_BASE +: NUM_IRQ];
                CSR_MTVEC:    mtvec_d    = {wval[XLEN-1:2], 1'b0,
                                            VECTORED_EN && (wval[1:0] == 2'b01)};
                CSR_MSCRATCH: mscratch_d = wval;
                CSR_MEPC:     mepc_d     = wval & ~XLEN'(3);
                CSR_MCAUSE:   mcause_d   = wval;
                CSR_MTVAL:    mtval_d    = wval;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_bit_q  <= 1'b0;
            mpie_q     <= 1'b0;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mscratch_q <= '0;
        end else begin
            mie_bit_q  <= mie_bit_d;
            mpie_q     <= mpie_d;
            mie_q      <= mie_d;
            mip_q      <= mip_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mscratch_q <= mscratch_d;
        end
    end

    assign mstatus_mie_o = mie_bit_q;
    assign mie_o         = mie_q;
    assign mip_o         = mip_q;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
endmodule

// File: rtl/trap_unit.sv
// rtl/trap_unit.sv - machine-mode trap controller: trap/mret FSM, priority, shadow latches, vectoring
// clk/rst: clock and async active-high reset
// bus (slave): CSR access from MEM, exception/mret/irq inputs, flush/stall/redirect outputs
module trap_unit
    import trap_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              NUM_IRQ     = 4,
    parameter bit              VECTORED_EN = 1'b1,
    parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    trap_unit_if.slave  bus
);
    trap_state_e        state_q, state_d;
    logic [XLEN-1:0]    cause_q, cause_d, epc_q, epc_d, tval_q, tval_d;
    logic               is_irq_q, is_irq_d;
    logic               idle, irq_take, flush, stall, redirect_valid;
    logic               trap_commit, mret_commit, csr_we, csr_legal, mstatus_mie;
    logic [XLEN-1:0]    redirect_pc, csr_raw, mtvec, mepc, vec_pc;
    logic [NUM_IRQ-1:0] mie, mip, pending;
    logic [7:0]         irq_code;

    assign idle     = (state_q == ST_IDLE);
    assign pending  = mip & mie;
    assign irq_take = idle && mstatus_mie && (pending != '0);

    // Lowest pending line wins: scan downward so the last hit is the smallest index.
    always_comb begin
        irq_code = 8'(IRQ_BASE);
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) irq_code = 8'(IRQ_BASE + i);
        end
    end

    always_comb begin
        vec_pc = {mtvec[XLEN-1:2], 2'b00};
        if (VECTORED_EN && (mtvec[1:0] == 2'b01) && is_irq_q)
            vec_pc = vec_pc + {{(XLEN-10){1'b0}}, cause_q[7:0], 2'b00};
    end

    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        epc_d          = epc_q;
        tval_d         = tval_q;
        is_irq_d       = is_irq_q;
        flush          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap_commit    = 1'b0;
        mret_commit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.exc_valid) begin
                    flush    = 1'b1;
                    state_d  = ST_TRAP;
                    cause_d  = {{(XLEN-4){1'b0}}, bus.exc_code};
                    epc_d    = bus.exc_pc;
                    tval_d   = bus.exc_tval;
                    is_irq_d = 1'b0;
                end else if (irq_take) begin
                    flush    = 1'b1;
                    state_d  = ST_TRAP;
                    cause_d  = {1'b1, {(XLEN-9){1'b0}}, irq_code};
                    epc_d    = bus.pc_next;
                    tval_d   = '0;
                    is_irq_d = 1'b1;
                end else if (bus.mret) begin
                    flush   = 1'b1;
                    state_d = ST_MRET;
                end
            end
            ST_TRAP: begin
                stall          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = vec_pc;
                trap_commit    = 1'b1;
                state_d        = ST_IDLE;
            end
            ST_MRET: begin
                stall          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = mepc;
                mret_commit    = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cause_q  <= '0;
            epc_q    <= '0;
            tval_q   <= '0;
            is_irq_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            tval_q   <= tval_d;
            is_irq_q <= is_irq_d;
        end
    end

    // A CSR write that coincides with a flush belongs to a cancelled instruction.
    assign csr_we = bus.csr_valid && idle && !flush;

    trap_csr_file #(
        .XLEN        (XLEN),
        .NUM_IRQ     (NUM_IRQ),
        .VECTORED_EN (VECTORED_EN),
        .RESET_MTVEC (RESET_MTVEC)
    ) u_csr (
        .clk           (clk),
        .rst           (rst),
        .irq_i         (bus.irq),
        .csr_we_i      (csr_we),
        .csr_op_i      (bus.csr_op),
        .csr_addr_i    (bus.csr_addr),
        .csr_wdata_i   (bus.csr_wdata),
        .csr_rdata_o   (csr_raw),
        .csr_legal_o   (csr_legal),
        .trap_commit_i (trap_commit),
        .trap_epc_i    (epc_q),
        .trap_cause_i  (cause_q),
        .trap_tval_i   (tval_q),
        .mret_commit_i (mret_commit),
        .mstatus_mie_o (mstatus_mie),
        .mie_o         (mie),
        .mip_o         (mip),
        .mtvec_o       (mtvec),
        .mepc_o        (mepc)
    );

    assign bus.csr_rdata      = (bus.csr_valid && idle && csr_legal) ? csr_raw : '0;
    assign bus.csr_illegal    = bus.csr_valid && idle && !csr_legal;
    assign bus.flush          = flush;
    assign bus.stall          = stall;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;
endmodule

// File: tb/tb_trap_unit.sv
// tb/tb_trap_unit.sv - directed self-checking bench for trap_unit
module tb_trap_unit;
    import trap_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    trap_unit_if #(.XLEN(32), .NUM_IRQ(4)) bus ();

    trap_unit #(
        .XLEN        (32),
        .NUM_IRQ     (4),
        .VECTORED_EN (1'b1),
        .RESET_MTVEC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One IDLE-cycle CSR instruction; checks the old value returned for rd.
    task automatic csr(input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_old, input string tag);
        bus.csr_valid = 1'b1;
        bus.csr_op    = op;
        bus.csr_addr  = addr;
        bus.csr_wdata = wdata;
        #1;
        chk(tag, bus.csr_rdata, exp_old);
        tick();
        bus.csr_valid = 1'b0;
        bus.csr_op    = CSR_OP_READ;
        bus.csr_wdata = '0;
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        csr(CSR_OP_READ, addr, 32'h0, exp, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.csr_valid = 1'b0; bus.csr_op = 2'b00; bus.csr_addr = '0; bus.csr_wdata = '0;
        bus.irq = '0; bus.exc_valid = 1'b0; bus.exc_code = '0; bus.exc_pc = '0;
        bus.exc_tval = '0; bus.mret = 1'b0; bus.pc_next = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        #1;
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        tick();
        rd(CSR_MSTATUS, 32'h0000_1800, "rst_mstatus");
        rd(CSR_MTVEC, 32'h0, "rst_mtvec");

        // Async reset while in TRAP discards the pending commit
        bus.exc_valid = 1'b1; bus.exc_code = EXC_ILLEGAL; bus.exc_pc = 32'h123C; bus.exc_tval = 32'h55;
        #1 chk("rtrap_flush", 32'(bus.flush), 32'd1);
        tick();
        bus.exc_valid = 1'b0;
        #1 chk("rtrap_redirect_before", 32'(bus.redirect_valid), 32'd1);
        rst = 1'b1;
        #1 chk("rtrap_redirect_drop", 32'(bus.redirect_valid), 32'd0);
        chk("rtrap_stall_drop", 32'(bus.stall), 32'd0);
        tick();
        rst = 1'b0;
        rd(CSR_MEPC, 32'h0, "rtrap_mepc");
        rd(CSR_MCAUSE, 32'h0, "rtrap_mcause");

        // Basic CSR write/set/clear
        csr(CSR_OP_WRITE, CSR_MTVEC, 32'h100, 32'h0, "csrrw_mtvec_old");
        csr(CSR_OP_SET, CSR_MIE, 32'h1_0000, 32'h0, "csrrs_mie_old");
        csr(CSR_OP_SET, CSR_MSTATUS, 32'h8, 32'h1800, "csrrs_mstatus_old");
        rd(CSR_MTVEC, 32'h100, "mtvec_rb");
        rd(CSR_MIE, 32'h1_0000, "mie_rb");
        rd(CSR_MSTATUS, 32'h1808, "mstatus_set_rb");
        csr(CSR_OP_CLEAR, CSR_MSTATUS, 32'h8, 32'h1808, "csrrc_mstatus_old");
        rd(CSR_MSTATUS, 32'h1800, "mstatus_clr_rb");

        // Write masks
        csr(CSR_OP_WRITE, CSR_MSTATUS, 32'hFFFF_FFFF, 32'h1800, "mstatus_all_old");
        rd(CSR_MSTATUS, 32'h1888, "mstatus_mask");
        csr(CSR_OP_WRITE, CSR_MTVEC, 32'h1F3, 32'h100, "mtvec_mode3_old");
        rd(CSR_MTVEC, 32'h1F0, "mtvec_mode3");
        csr(CSR_OP_WRITE, CSR_MTVEC, 32'h100, 32'h1F0, "mtvec_restore_old");
        csr(CSR_OP_WRITE, CSR_MEPC, 32'h123, 32'h0, "mepc_old");
        rd(CSR_MEPC, 32'h120, "mepc_mask");
        csr(CSR_OP_WRITE, CSR_MIE, 32'hFFFF_FFFF, 32'h1_0000, "mie_all_old");
        rd(CSR_MIE, 32'h000F_0000, "mie_mask");
        csr(CSR_OP_WRITE, CSR_MIE, 32'h1_0000, 32'h000F_0000, "mie_restore_old");
        csr(CSR_OP_WRITE, CSR_MIP, 32'h000F_0000, 32'h0, "mip_write_old");
        rd(CSR_MIP, 32'h0, "mip_ro");

        // Unknown address
        bus.csr_valid = 1'b1; bus.csr_op = CSR_OP_WRITE; bus.csr_addr = 12'h7FF; bus.csr_wdata = 32'h55;
        #1 chk("illegal_flag", 32'(bus.csr_illegal), 32'd1);
        chk("illegal_rdata", bus.csr_rdata, 32'h0);
        tick();
        bus.csr_valid = 1'b0;
        rd(CSR_MSCRATCH, 32'h0, "illegal_nowrite");

        // ecall with MIE=1, MPIE=0
        csr(CSR_OP_WRITE, CSR_MSTATUS, 32'h8, 32'h1888, "pre_ecall_old");
        bus.exc_valid = 1'b1; bus.exc_code = EXC_ECALL_M; bus.exc_pc = 32'h40; bus.exc_tval = 32'h0;
        #1 chk("ecall_flush_N", 32'(bus.flush), 32'd1);
        chk("ecall_no_redirect_N", 32'(bus.redirect_valid), 32'd0);
        tick();
        bus.exc_valid = 1'b0;
        #1 chk("ecall_redirect_N1", 32'(bus.redirect_valid), 32'd1);
        chk("ecall_redirect_pc", bus.redirect_pc, 32'h100);
        chk("ecall_stall", 32'(bus.stall), 32'd1);
        chk("ecall_flush_N1", 32'(bus.flush), 32'd0);
        tick();
        #1 chk("ecall_redirect_N2", 32'(bus.redirect_valid), 32'd0);
        tick();
        rd(CSR_MEPC, 32'h40, "ecall_mepc");
        rd(CSR_MCAUSE, 32'd11, "ecall_mcause");
        rd(CSR_MSTATUS, 32'h1880, "ecall_mstatus");

        // Vectored interrupt on irq[1]
        csr(CSR_OP_WRITE, CSR_MTVEC, 32'h201, 32'h100, "vec_mtvec_old");
        csr(CSR_OP_SET, CSR_MIE, 32'h2_0000, 32'h1_0000, "vec_mie_old");
        csr(CSR_OP_SET, CSR_MSTATUS, 32'h8, 32'h1880, "vec_mstatus_old");
        bus.pc_next = 32'h88;
        bus.irq = 4'b0010;
        #1 chk("irq_latency", 32'(bus.flush), 32'd0);
        tick();
        #1 chk("irq_flush", 32'(bus.flush), 32'd1);
        tick();
        #1 chk("irq_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        chk("irq_redirect_pc", bus.redirect_pc, 32'h244);
        tick();
        #1 chk("irq_masked_after", 32'(bus.flush), 32'd0);
        tick();
        rd(CSR_MCAUSE, 32'h8000_0011, "irq_mcause");
        rd(CSR_MEPC, 32'h88, "irq_mepc");
        rd(CSR_MSTATUS, 32'h1880, "irq_mstatus");
        rd(CSR_MIP, 32'h2_0000, "irq_mip");

        // mret then immediate re-entry of the still-pending interrupt
        bus.mret = 1'b1;
        #1 chk("mret_flush", 32'(bus.flush), 32'd1);
        tick();
        bus.mret = 1'b0;
        #1 chk("mret_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        chk("mret_redirect_pc", bus.redirect_pc, 32'h88);
        tick();
        bus.csr_valid = 1'b1; bus.csr_op = CSR_OP_READ; bus.csr_addr = CSR_MSTATUS;
        #1 chk("mret_mstatus", bus.csr_rdata, 32'h1888);
        chk("reentry_flush", 32'(bus.flush), 32'd1);
        tick();
        bus.csr_valid = 1'b0;
        #1 chk("reentry_redirect_pc", bus.redirect_pc, 32'h244);
        tick();
        bus.irq = 4'b0000;
        #1 chk("reentry_done", 32'(bus.redirect_valid), 32'd0);
        tick();
        rd(CSR_MSTATUS, 32'h1880, "reentry_mstatus");

        // Simultaneous exception, interrupt and CSR write
        bus.irq = 4'b0001;
        #1 chk("simul_pend_noflush", 32'(bus.flush), 32'd0);
        tick();
        csr(CSR_OP_SET, CSR_MSTATUS, 32'h8, 32'h1880, "simul_mie_old");
        bus.exc_valid = 1'b1; bus.exc_code = EXC_ILLEGAL; bus.exc_pc = 32'h60; bus.exc_tval = 32'hDEAD;
        bus.csr_valid = 1'b1; bus.csr_op = CSR_OP_WRITE; bus.csr_addr = CSR_MSCRATCH; bus.csr_wdata = 32'h55;
        #1 chk("simul_flush", 32'(bus.flush), 32'd1);
        tick();
        bus.exc_valid = 1'b0; bus.csr_valid = 1'b0; bus.csr_op = CSR_OP_READ; bus.csr_wdata = '0;
        #1 chk("simul_redirect_pc", bus.redirect_pc, 32'h200);
        tick();
        rd(CSR_MCAUSE, 32'd2, "simul_mcause");
        rd(CSR_MTVAL, 32'hDEAD, "simul_mtval");
        rd(CSR_MEPC, 32'h60, "simul_mepc");
        rd(CSR_MSCRATCH, 32'h0, "simul_mscratch");
        bus.mret = 1'b1;
        #1 chk("simul_mret_flush", 32'(bus.flush), 32'd1);
        tick();
        bus.mret = 1'b0;
        #1 chk("simul_mret_pc", bus.redirect_pc, 32'h60);
        tick();
        #1 chk("simul_irq_flush", 32'(bus.flush), 32'd1);
        tick();
        #1 chk("simul_irq_pc", bus.redirect_pc, 32'h240);
        tick();
        bus.irq = 4'b0000;
        tick();
        rd(CSR_MCAUSE, 32'h8000_0010, "simul_irq_mcause");
        rd(CSR_MTVAL, 32'h0, "simul_irq_mtval");
        rd(CSR_MEPC, 32'h88, "simul_irq_mepc");
        csr(CSR_OP_WRITE, CSR_MSCRATCH, 32'h55, 32'h0, "mscratch_old");
        rd(CSR_MSCRATCH, 32'h55, "mscratch_rb");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
